// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant per cyc, combinational
// passthrough of the granted master, and a stall watchdog raising err.
module wb_arbiter2 #(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last;
    logic               last_nxt;
    logic [CNT_W-1:0]   wd_cnt;
    logic               err0;
    logic               err1;
    logic               wd_clear;
    logic               wd_hit;

    // State register; last=1 after reset so master 0 wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: grants only leave through IDLE, so handoffs never overlap
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux driven purely from the current grant
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
            end
            default: begin
            end
        endcase
    end

    // Ack in the terminal-count cycle clears the counter before the hit matters
    assign wd_clear = (state == IDLE) || !s_stb_o || s_ack_i;
    assign wd_hit   = (wd_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
            err0   <= 1'b0;
            err1   <= 1'b0;
        end else begin
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (wd_clear) begin
                wd_cnt <= '0;
            end else if (wd_hit) begin
                wd_cnt <= '0;
                err0   <= (state == GNT0);
                err1   <= (state == GNT1);
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

    assign m0_err_o = err0;
    assign m1_err_o = err1;

endmodule
